// File: rtl/process_scheduler.sv
// -----------------------------------------------------------------------------
// process_scheduler
//
// Round-robin time-slice scheduler for up to NPROC user processes (ids
// 1..NPROC). A start pulse loads the process count and marks those processes
// unfinished. The scheduler then cycles through them. Each slice lasts QUANTUM
// retired instructions. A slice ends early on an IN/OUT yield. A finished
// process is dropped without a context save.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : one-cycle launch pulse (honoured in IDLE/DONE only)
//   num_procs    : process count, sampled with an accepted start
//   instr_step   : one instruction of cur_proc retired this cycle
//   io_yield     : cur_proc executed IN/OUT and yields
//   proc_end     : cur_proc executed its end instruction
//   save_done    : context-save routine finished
//   switch_req   : request context save of cur_proc (high throughout SAVE)
//   cur_proc     : running process id, 0 when none
//   pc_base      : cur_proc * PROC_STRIDE
//   quantum_left : instructions remaining in the current slice
//   busy         : high in SELECT, RUN and SAVE
//   all_done     : high in DONE
// -----------------------------------------------------------------------------
module process_scheduler #(
  parameter int NPROC       = 10,
  parameter int QUANTUM     = 16,
  parameter int PROC_STRIDE = 300
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  num_procs,
  input  logic        instr_step,
  input  logic        io_yield,
  input  logic        proc_end,
  input  logic        save_done,
  output logic        switch_req,
  output logic [3:0]  cur_proc,
  output logic [31:0] pc_base,
  output logic [7:0]  quantum_left,
  output logic        busy,
  output logic        all_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RUN,
    S_SAVE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  count;
  logic [15:0] unf;          // bit i set while process i is unfinished

  logic        accept;
  logic        pick;
  logic        go_done;
  logic        finish;
  logic        dec;

  logic [3:0]  eff_count;
  logic [15:0] start_mask;
  logic [4:0]  cand;
  logic        sel_found;
  logic [3:0]  sel_id;
  logic [31:0] sel_pc;

  // Requests for more processes than exist are saturated to NPROC.
  function automatic logic [3:0] clamp_count(input logic [3:0] n);
    if (n > 4'(NPROC)) begin
      return 4'(NPROC);
    end
    return n;
  endfunction

  assign eff_count = clamp_count(num_procs);

  always_comb begin
    start_mask = '0;
    for (int i = 1; i < 16; i++) begin
      start_mask[i] = (i <= int'(eff_count));
    end
  end

  // Scan upward from the id after cur_proc and wrap from count back to 1.
  // The last candidate examined is cur_proc itself. This lets a sole
  // survivor be re-picked. cur_proc <= count always holds, and so does
  // k <= count. A single subtraction therefore performs the wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = 4'd0;
    cand      = 5'd0;
    for (int k = 1; k <= NPROC; k++) begin
      cand = {1'b0, cur_proc} + 5'(k);
      if (cand > {1'b0, count}) begin
        cand = cand - {1'b0, count};
      end
      if (!sel_found && (k <= int'(count)) && unf[cand[3:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[3:0];
      end
    end
  end

  assign sel_pc = 32'(sel_id) * 32'(PROC_STRIDE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pick      = 1'b0;
    go_done   = 1'b0;
    finish    = 1'b0;
    dec       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && (num_procs != 4'd0)) begin
          accept    = 1'b1;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          pick      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          go_done   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        // Priority: process end, then IN/OUT yield, then quantum expiry.
        if (proc_end) begin
          finish    = 1'b1;
          state_nxt = S_SELECT;
        end else if (io_yield) begin
          state_nxt = S_SAVE;
        end else if (instr_step) begin
          dec = 1'b1;
          if (quantum_left == 8'd1) begin
            state_nxt = S_SAVE;
          end
        end
      end
      S_SAVE: begin
        if (save_done) begin
          state_nxt = S_SELECT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count        <= 4'd0;
      unf          <= '0;
      cur_proc     <= 4'd0;
      pc_base      <= 32'd0;
      quantum_left <= 8'd0;
    end else begin
      if (accept) begin
        count    <= eff_count;
        unf      <= start_mask;
        cur_proc <= 4'd0;
        pc_base  <= 32'd0;
      end
      if (pick) begin
        cur_proc     <= sel_id;
        pc_base      <= sel_pc;
        quantum_left <= 8'(QUANTUM);
      end
      if (go_done) begin
        cur_proc <= 4'd0;
        pc_base  <= 32'd0;
      end
      if (finish) begin
        unf[cur_proc] <= 1'b0;
      end
      if (dec) begin
        quantum_left <= quantum_left - 8'd1;
      end
    end
  end

  assign switch_req = (state == S_SAVE);
  assign busy       = (state == S_SELECT) || (state == S_RUN) || (state == S_SAVE);
  assign all_done   = (state == S_DONE);

endmodule

// File: tb/tb_process_scheduler.sv
module tb_process_scheduler;

  localparam int NPROC       = 10;
  localparam int QUANTUM     = 16;
  localparam int PROC_STRIDE = 300;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_procs;
  logic        instr_step;
  logic        io_yield;
  logic        proc_end;
  logic        save_done;
  logic        switch_req;
  logic [3:0]  cur_proc;
  logic [31:0] pc_base;
  logic [7:0]  quantum_left;
  logic        busy;
  logic        all_done;

  process_scheduler #(
    .NPROC(NPROC),
    .QUANTUM(QUANTUM),
    .PROC_STRIDE(PROC_STRIDE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .num_procs(num_procs),
    .instr_step(instr_step),
    .io_yield(io_yield),
    .proc_end(proc_end),
    .save_done(save_done),
    .switch_req(switch_req),
    .cur_proc(cur_proc),
    .pc_base(pc_base),
    .quantum_left(quantum_left),
    .busy(busy),
    .all_done(all_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sw;
    logic [3:0]  cur;
    logic [31:0] pc;
    logic [7:0]  q;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: scheduler phase plus a table of which ids still have work.
  localparam int M_IDLE = 0, M_SEL = 1, M_RUN = 2, M_SAVE = 3, M_DONE = 4;
  int m_mode = M_IDLE;
  int m_cnt  = 0;
  int m_cur  = 0;
  int m_q    = 0;
  bit m_unf[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int next_pick();
    for (int off = 1; off <= m_cnt; off++) begin
      int id;
      id = ((m_cur + off - 1) % m_cnt) + 1;
      if (m_unf[id]) return id;
    end
    return 0;
  endfunction

  task automatic model_step(input bit rst, input bit st, input int n,
                            input bit ins, input bit io, input bit pe, input bit sd);
    int nid;
    if (rst) begin
      m_mode = M_IDLE; m_cur = 0; m_q = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) m_unf[i] = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (st && n != 0) begin
            m_cnt = (n > NPROC) ? NPROC : n;
            for (int i = 0; i < 16; i++) m_unf[i] = (i >= 1) && (i <= m_cnt);
            m_cur  = 0;
            m_mode = M_SEL;
          end
        end
        M_SEL: begin
          nid = next_pick();
          if (nid == 0) begin
            m_cur = 0; m_mode = M_DONE;
          end else begin
            m_cur = nid; m_q = QUANTUM; m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (pe) begin
            m_unf[m_cur] = 1'b0; m_mode = M_SEL;
          end else if (io) begin
            m_mode = M_SAVE;
          end else if (ins) begin
            m_q = m_q - 1;
            if (m_q == 0) m_mode = M_SAVE;
          end
        end
        M_SAVE: if (sd) m_mode = M_SEL;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.sw   = (m_mode == M_SAVE);
    e.cur  = 4'(m_cur);
    e.pc   = 32'(m_cur * PROC_STRIDE);
    e.q    = 8'(m_q);
    e.busy = (m_mode == M_SEL) || (m_mode == M_RUN) || (m_mode == M_SAVE);
    e.done = (m_mode == M_DONE);
    return e;
  endfunction

  // Apply one cycle of inputs (from a falling edge), queue the expected
  // post-edge outputs, and advance to the next falling edge.
  task automatic drive(input bit rst, input bit st, input logic [3:0] n,
                       input bit ins, input bit io, input bit pe, input bit sd);
    reset = rst; start = st; num_procs = n;
    instr_step = ins; io_yield = io; proc_end = pe; save_done = sd;
    model_step(rst, st, int'(n), ins, io, pe, sd);
    sb.push_back(model_out());
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic steps(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 4'd0, 1, 0, 0, 0);
  endtask

  // Monitor: compares one queued expectation per clock edge.
  always begin
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("switch_req",   32'(switch_req),   32'(mon_e.sw));
      chk("cur_proc",     32'(cur_proc),     32'(mon_e.cur));
      chk("pc_base",      pc_base,           mon_e.pc);
      chk("quantum_left", 32'(quantum_left), 32'(mon_e.q));
      chk("busy",         32'(busy),         32'(mon_e.busy));
      chk("all_done",     32'(all_done),     32'(mon_e.done));
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_procs = 4'd0;
    instr_step = 1'b0; io_yield = 1'b0; proc_end = 1'b0; save_done = 1'b0;

    // Reset state, then quantum expiry on process 1 and switch to process 2.
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(0, 1, 4'd3, 0, 0, 0, 0);
    idle(1);
    steps(16);
    idle(2);
    drive(0, 0, 4'd0, 0, 0, 0, 1);
    idle(2);

    // IN/OUT yields on process 2 and process 3, then wrap back to process 1.
    steps(3);
    drive(0, 0, 4'd0, 0, 1, 0, 0);
    drive(0, 0, 4'd0, 0, 0, 0, 1);
    idle(1);
    steps(5);
    drive(0, 0, 4'd0, 1, 1, 0, 0);
    idle(1);
    drive(0, 0, 4'd0, 0, 0, 0, 1);
    idle(2);

    // All three processes end in turn: no saves, then DONE.
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(0, 1, 4'd3, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      idle(1);
      drive(0, 0, 4'd0, 1, 0, 1, 0);
    end
    idle(3);

    // End and yield together on process 2 of 2.
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(0, 1, 4'd2, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 4'd0, 0, 1, 0, 0);
    drive(0, 0, 4'd0, 0, 0, 0, 1);
    idle(1);
    drive(0, 0, 4'd0, 1, 1, 1, 0);
    idle(3);

    // Reset in the middle of SAVE, then an over-range start.
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(0, 1, 4'd3, 0, 0, 0, 0);
    idle(1);
    steps(16);
    idle(2);
    reset = 1'b1;
    #1;
    chk("async_switch_req", 32'(switch_req),   32'd0);
    chk("async_cur_proc",   32'(cur_proc),     32'd0);
    chk("async_pc_base",    pc_base,           32'd0);
    chk("async_quantum",    32'(quantum_left), 32'd0);
    chk("async_busy",       32'(busy),         32'd0);
    chk("async_all_done",   32'(all_done),     32'd0);
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(0, 1, 4'd12, 0, 0, 0, 0);
    for (int p = 0; p < 11; p++) begin
      idle(1);
      drive(0, 0, 4'd0, 0, 0, 1, 0);
    end
    idle(2);

    // Zero-process start is ignored.
    drive(1, 0, 4'd0, 0, 0, 0, 0);
    drive(0, 1, 4'd0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      bit r, st, ins, io, pe, sd;
      logic [3:0] n;
      r   = ($urandom_range(0, 499) == 0);
      st  = ($urandom_range(0, 99) < 4);
      n   = 4'($urandom_range(0, 15));
      ins = ($urandom_range(0, 99) < 60);
      io  = ($urandom_range(0, 99) < 5);
      pe  = ($urandom_range(0, 99) < 4);
      sd  = ($urandom_range(0, 99) < 30);
      drive(r, st, n, ins, io, pe, sd);
    end

    @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
